seq_alu: RTL

Parametrised multi-cycle ALU with valid/ready handshakes on operand and result sides. It keeps the established 3-bit opcode set (sla, sra, add, sub, mul, and, or, not) and the 3-bit flag output. Multiplication is a signed iterative shift-add over WIDTH cycles; all other ops complete in one cycle. It sits between the operand-issue logic and the writeback stage of the datapath.

---
 rtl/seq_alu_pkg.sv | 24 ++
 rtl/seq_alu_mul.sv | 72 +++++++
 rtl/seq_alu.sv | 175 +++++++++++++++++
 3 files changed

// File: rtl/seq_alu_pkg.sv
// seq_alu_pkg: shared constants for the sequential ALU.
//   - OP_*   : 3-bit opcode encoding
//   - ST_*   : controller state encoding (IDLE / MUL / DONE)
//   - FLAG_* : bit positions inside the 3-bit flag output d
package seq_alu_pkg;

  localparam logic [2:0] OP_SLA = 3'b000;
  localparam logic [2:0] OP_SRA = 3'b001;
  localparam logic [2:0] OP_ADD = 3'b010;
  localparam logic [2:0] OP_SUB = 3'b011;
  localparam logic [2:0] OP_MUL = 3'b100;
  localparam logic [2:0] OP_AND = 3'b101;
  localparam logic [2:0] OP_OR  = 3'b110;
  localparam logic [2:0] OP_NOT = 3'b111;

  localparam logic [1:0] ST_IDLE = 2'b00;
  localparam logic [1:0] ST_MUL  = 2'b01;
  localparam logic [1:0] ST_DONE = 2'b10;

  localparam int FLAG_Z = 0;
  localparam int FLAG_N = 1;
  localparam int FLAG_V = 2;

endpackage

// File: rtl/seq_alu_mul.sv
// seq_alu_mul: iterative signed shift-add multiplier.
// Operands are converted to magnitudes on start; one partial product is
// folded in per cycle for WIDTH cycles and the sign is reapplied at the end.
// Ports:
//   clk, rst     : clock, asynchronous active-high reset
//   start        : load a/b and begin a new multiplication
//   a, b         : signed operands (sampled on start)
//   done         : high in the cycle whose rising edge completes the product
//   product      : full 2*WIDTH signed product, valid while done is high
//   ovf          : product upper half is not the sign extension of the lower
module seq_alu_mul #(
  parameter int WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  output logic                 done,
  output logic [2*WIDTH-1:0]   product,
  output logic                 ovf
);

  localparam int CW = $clog2(WIDTH) + 1;

  logic [WIDTH-1:0]   mcand_reg;
  logic [WIDTH-1:0]   mplier_reg;
  logic [2*WIDTH-1:0] acc_reg;
  logic [2*WIDTH-1:0] acc_next;
  logic [CW-1:0]      count_reg;
  logic               sign_reg;
  logic [WIDTH:0]     sum;
  logic [2*WIDTH-1:0] prod;
  logic               acc_lsb_unused;

  // Upper half plus optional multiplicand, keeping the carry so the
  // right shift below pulls it into the accumulator MSB.
  assign sum      = {1'b0, acc_reg[2*WIDTH-1:WIDTH]}
                  + (mplier_reg[0] ? {1'b0, mcand_reg} : '0);
  assign acc_next = {sum, acc_reg[WIDTH-1:1]};

  // The bit shifted out of the accumulator each step carries no information.
  assign acc_lsb_unused = acc_reg[0];

  // Completion is taken from the final step's next-state value so the
  // result lands on the same edge the counter reaches zero.
  assign prod    = sign_reg ? (~acc_next + 1'b1) : acc_next;
  assign done    = (count_reg == CW'(1));
  assign product = prod;
  assign ovf     = (prod[2*WIDTH-1:WIDTH] != {WIDTH{prod[WIDTH-1]}});

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mcand_reg  <= '0;
      mplier_reg <= '0;
      acc_reg    <= '0;
      count_reg  <= '0;
      sign_reg   <= 1'b0;
    end else if (start) begin
      mcand_reg  <= a[WIDTH-1] ? (~a + 1'b1) : a;
      mplier_reg <= b[WIDTH-1] ? (~b + 1'b1) : b;
      sign_reg   <= a[WIDTH-1] ^ b[WIDTH-1];
      acc_reg    <= '0;
      count_reg  <= CW'(WIDTH);
    end else if (count_reg != '0) begin
      acc_reg    <= acc_next;
      mplier_reg <= mplier_reg >> 1;
      count_reg  <= count_reg - 1'b1;
    end
  end

endmodule

// File: rtl/seq_alu.sv
// seq_alu: multi-cycle ALU with valid/ready handshakes on both sides.
// Single-cycle ops: sla, sra, add, sub, and, or, not. mul runs WIDTH cycles
// in seq_alu_mul. Optional macro SEQ_ALU_HI_EN adds output c_hi carrying the
// upper half of the signed product (sign extension of c for other ops).
// Ports:
//   clk, rst            : clock, asynchronous active-high reset
//   in_valid, in_ready  : operand handshake
//   a, b, opcode        : operands (shift amount = b[SHW-1:0]) and op select
//   out_valid, out_ready: result handshake
//   c                   : result (low WIDTH bits for mul)
//   d                   : flags {overflow, negative, zero}
//   c_hi                : (SEQ_ALU_HI_EN only) upper product half
module seq_alu
  import seq_alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       opcode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] c,
  output logic [2:0]       d
`ifdef SEQ_ALU_HI_EN
  ,
  output logic [WIDTH-1:0] c_hi
`endif
);

  localparam int SHW = $clog2(WIDTH);

  logic [1:0]         state_reg;
  logic [WIDTH-1:0]   c_reg;
  logic [2:0]         d_reg;
  logic               out_valid_reg;
  logic               accept;
  logic               mul_start;
  logic               mul_done;
  logic               mul_ovf;
  logic [2*WIDTH-1:0] mul_prod;
  logic [SHW-1:0]     shamt;
  logic [WIDTH-1:0]   sla_diff;
  logic [WIDTH-1:0]   alu_res;
  logic               alu_v;

  function automatic logic [2:0] make_flags(input logic [WIDTH-1:0] r,
                                            input logic v);
    logic [2:0] f;
    f         = '0;
    f[FLAG_Z] = (r == '0);
    f[FLAG_N] = r[WIDTH-1];
    f[FLAG_V] = v;
    return f;
  endfunction

  assign in_ready  = (state_reg == ST_IDLE) || ((state_reg == ST_DONE) && out_ready);
  assign accept    = in_valid && in_ready;
  assign mul_start = accept && (opcode == OP_MUL);
  assign shamt     = b[SHW-1:0];

  // sla overflows when any bit from the new sign position upward differs
  // from the original sign: that covers both lost bits and a flipped sign.
  genvar gi;
  generate
    for (gi = 0; gi < WIDTH; gi++) begin : g_sla
      assign sla_diff[gi] = (a[gi] != a[WIDTH-1]) && (shamt >= SHW'(WIDTH-1-gi));
    end
  endgenerate

  always_comb begin
    alu_res = '0;
    alu_v   = 1'b0;
    case (opcode)
      OP_SLA: begin
        alu_res = a << shamt;
        alu_v   = |sla_diff;
      end
      OP_SRA: alu_res = $signed(a) >>> shamt;
      OP_ADD: begin
        alu_res = a + b;
        alu_v   = (a[WIDTH-1] == b[WIDTH-1]) && (alu_res[WIDTH-1] != a[WIDTH-1]);
      end
      OP_SUB: begin
        alu_res = a - b;
        alu_v   = (a[WIDTH-1] != b[WIDTH-1]) && (alu_res[WIDTH-1] != a[WIDTH-1]);
      end
      OP_AND: alu_res = a & b;
      OP_OR:  alu_res = a | b;
      OP_NOT: alu_res = ~a;
      OP_MUL: alu_res = '0;
      default: alu_res = '0;
    endcase
  end

  seq_alu_mul #(.WIDTH(WIDTH)) u_mul (
    .clk     (clk),
    .rst     (rst),
    .start   (mul_start),
    .a       (a),
    .b       (b),
    .done    (mul_done),
    .product (mul_prod),
    .ovf     (mul_ovf)
  );

`ifdef SEQ_ALU_HI_EN
  logic [WIDTH-1:0] c_hi_reg;
  assign c_hi = c_hi_reg;
`else
  // Upper half only feeds the overflow flag inside the multiplier.
  logic [WIDTH-1:0] mul_hi_unused;
  assign mul_hi_unused = mul_prod[2*WIDTH-1:WIDTH];
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg     <= ST_IDLE;
      c_reg         <= '0;
      d_reg         <= '0;
      out_valid_reg <= 1'b0;
`ifdef SEQ_ALU_HI_EN
      c_hi_reg      <= '0;
`endif
    end else begin
      case (state_reg)
        ST_MUL: begin
          if (mul_done) begin
            state_reg     <= ST_DONE;
            c_reg         <= mul_prod[WIDTH-1:0];
            d_reg         <= make_flags(mul_prod[WIDTH-1:0], mul_ovf);
            out_valid_reg <= 1'b1;
`ifdef SEQ_ALU_HI_EN
            c_hi_reg      <= mul_prod[2*WIDTH-1:WIDTH];
`endif
          end
        end
        ST_IDLE, ST_DONE: begin
          // DONE with out_ready retires the result; a simultaneous new op
          // is taken in the same cycle.
          if (accept) begin
            if (opcode == OP_MUL) begin
              state_reg     <= ST_MUL;
              out_valid_reg <= 1'b0;
            end else begin
              state_reg     <= ST_DONE;
              c_reg         <= alu_res;
              d_reg         <= make_flags(alu_res, alu_v);
              out_valid_reg <= 1'b1;
`ifdef SEQ_ALU_HI_EN
              c_hi_reg      <= {WIDTH{alu_res[WIDTH-1]}};
`endif
            end
          end else if ((state_reg == ST_DONE) && out_ready) begin
            state_reg     <= ST_IDLE;
            out_valid_reg <= 1'b0;
          end
        end
        default: begin
          state_reg     <= ST_IDLE;
          out_valid_reg <= 1'b0;
        end
      endcase
    end
  end

  assign c         = c_reg;
  assign d         = d_reg;
  assign out_valid = out_valid_reg;

endmodule
